fft_peak_detect: RTL and testbench

- Streaming consumer directly downstream of the FFT output port.
- Takes one 32-bit complex bin per valid cycle: {re[15:0], im[15:0]}, both signed two's complement.
- Computes an L1 magnitude for each bin and tracks the strongest bin in the lower half-spectrum.
- Reports the peak bin index and magnitude once per frame; the harmonizer pitch-shift control uses this as the detected fundamental.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_mag_l1.sv | 22 ++
 rtl/fft_peak_detect.sv | 133 +++++++++++++
 tb/tb_fft_peak_detect.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT peak detector.
package fft_pkg;

    localparam int FFT_N_BINS = 64;
    localparam int FFT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } peak_state_t;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_mag_l1.sv
// Combinational L1 magnitude |re|+|im| of one complex bin.
// The most negative input maps to 2^(DATA_W-1) without saturation, and the
// extra output bit lets the largest possible sum 2^DATA_W fit exactly.
module fft_mag_l1 #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] re,
    input  logic [DATA_W-1:0] im,
    output logic [DATA_W:0]   mag
);

    logic [DATA_W-1:0] abs_re;
    logic [DATA_W-1:0] abs_im;

    // two's-complement absolute value, unsigned result of the same width
    always_comb begin
        abs_re = re[DATA_W-1] ? (~re + DATA_W'(1)) : re;
        abs_im = im[DATA_W-1] ? (~im + DATA_W'(1)) : im;
        mag    = {1'b0, abs_re} + {1'b0, abs_im};
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming peak detector for FFT output frames.
// Tracks the strongest L1-magnitude bin in the lower half-spectrum and
// reports it once per frame. Build option FFT_PEAK_DC_SKIP_EN excludes bin 0
// from the search (running index then starts at 1).
//
// state | meaning
// IDLE  | waiting for start; in_valid ignored
// ACCUM | consuming bins 0..N_BINS-1
// FLUSH | last bin is in the compare stage
// DONE  | running max final; result loaded into the output registers
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int N_BINS = FFT_N_BINS,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [2*DATA_W-1:0]       in_data,
    output logic                      busy,
    output logic                      peak_valid,
    output logic [$clog2(N_BINS)-1:0] peak_bin,
    output logic [DATA_W:0]           peak_mag
);

    localparam int IDX_W = $clog2(N_BINS);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BINS - 1);
`ifdef FFT_PEAK_DC_SKIP_EN
    localparam logic [IDX_W-1:0] RUN_IDX_INIT = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] RUN_IDX_INIT = '0;
`endif

    peak_state_t       state;
    peak_state_t       state_next;
    logic [IDX_W-1:0]  bin_cnt;
    logic              take_bin;
    logic [DATA_W:0]   mag_comb;

    logic              s1_valid;
    logic [IDX_W-1:0]  s1_bin;
    logic [DATA_W:0]   s1_mag;
    logic              s1_considered;

    logic [DATA_W:0]   run_max;
    logic [IDX_W-1:0]  run_idx;

    assign take_bin = (state == ACCUM) && in_valid;
    assign busy     = (state != IDLE);

    // upper half of the spectrum mirrors the lower half, so only MSB=0 bins compete
`ifdef FFT_PEAK_DC_SKIP_EN
    assign s1_considered = s1_valid && !s1_bin[IDX_W-1] && (s1_bin != '0);
`else
    assign s1_considered = s1_valid && !s1_bin[IDX_W-1];
`endif

    fft_mag_l1 #(.DATA_W(DATA_W)) u_mag (
        .re  (in_data[2*DATA_W-1:DATA_W]),
        .im  (in_data[DATA_W-1:0]),
        .mag (mag_comb)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state logic; start restarts the frame from any state
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ACCUM;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ACCUM:   if (take_bin && (bin_cnt == LAST_BIN)) state_next = FLUSH;
                FLUSH:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // bin counter; wraps to 0 after the last bin
    always_ff @(posedge clk) begin
        if (reset || start) bin_cnt <= '0;
        else if (take_bin)  bin_cnt <= bin_cnt + IDX_W'(1);
    end

    // stage 1: register magnitude, index and valid; start discards any bin in flight
    always_ff @(posedge clk) begin
        if (reset || start) begin
            s1_valid <= 1'b0;
            s1_bin   <= '0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= take_bin;
            s1_bin   <= bin_cnt;
            s1_mag   <= mag_comb;
        end
    end

    // stage 2: strict greater-than so ties keep the earlier (lower) index
    always_ff @(posedge clk) begin
        if (reset || start) begin
            run_max <= '0;
            run_idx <= RUN_IDX_INIT;
        end else if (s1_considered && (s1_mag > run_max)) begin
            run_max <= s1_mag;
            run_idx <= s1_bin;
        end
    end

    // result registers: loaded at the end of DONE, held until the next start
    always_ff @(posedge clk) begin
        if (reset || start) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            peak_valid <= (state == DONE);
            if (state == DONE) begin
                peak_bin <= run_idx;
                peak_mag <= run_max;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect (directed + random frames).
module tb_fft_peak_detect;
    import fft_pkg::*;

    localparam int NB = 64;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [2*DW-1:0] in_data = '0;
    logic          busy;
    logic          peak_valid;
    logic [5:0]    peak_bin;
    logic [DW:0]   peak_mag;

    int bin_re [NB];
    int bin_im [NB];
    int exp_bin, exp_mag;
    int n_total = 0;
    int n_pass  = 0;
    int pv_count = 0;
    int pv_before;

    fft_peak_detect #(.N_BINS(NB), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag)
    );

    always #5 clk = ~clk;

    // count every peak_valid pulse seen on a clock edge
    always @(posedge clk) if (peak_valid) pv_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*DW-1:0] pack_bin(input int k);
        cplx_t w;
        w.re = DW'(bin_re[k]);
        w.im = DW'(bin_im[k]);
        return w;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic clear_frame;
        for (int k = 0; k < NB; k++) begin
            bin_re[k] = 0;
            bin_im[k] = 0;
        end
    endtask

    // reference: strongest |re|+|im| among lower-half bins, first index wins ties
    task automatic model;
        int lo;
`ifdef FFT_PEAK_DC_SKIP_EN
        lo = 1;
`else
        lo = 0;
`endif
        exp_bin = lo;
        exp_mag = 0;
        for (int k = lo; k < NB / 2; k++) begin
            if (iabs(bin_re[k]) + iabs(bin_im[k]) > exp_mag) begin
                exp_mag = iabs(bin_re[k]) + iabs(bin_im[k]);
                exp_bin = k;
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between bins, 2 random idles
    task automatic send_bins(input string tag, input int nb, input int gap_mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_bin_cleared"}, 32'(peak_bin), 32'd0);
        for (int k = 0; k < nb; k++) begin
            in_valid = 1'b1;
            in_data  = pack_bin(k);
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            if (k < nb - 1) begin
                if (gap_mode == 1) tick();
                else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic wait_peak(input string tag);
        int n;
        logic busy2;
        n = 1;
        busy2 = 1'b0;
        while (!peak_valid && n < 10) begin
            if (n == 2) busy2 = busy;
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_busy_before_peak"}, 32'(busy2), 32'd1);
        check({tag, "_peak_valid"}, 32'(peak_valid), 32'd1);
        check({tag, "_busy_at_peak"}, 32'(busy), 32'd0);
        check({tag, "_bin"}, 32'(peak_bin), 32'(exp_bin));
        check({tag, "_mag"}, 32'(peak_mag), 32'(exp_mag));
        tick();
        check({tag, "_pulse_one_cycle"}, 32'(peak_valid), 32'd0);
        check({tag, "_bin_held"}, 32'(peak_bin), 32'(exp_bin));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(peak_valid), 32'd0);
        check("rst_bin", 32'(peak_bin), 32'd0);
        check("rst_mag", 32'(peak_mag), 32'd0);

        // single tone
        clear_frame();
        bin_re[5] = 100; bin_im[5] = -50;
        model();
        check("tone_model_bin", 32'(exp_bin), 32'd5);
        send_bins("tone", NB, 0);
        wait_peak("tone");

        // mirror bin ignored, tie keeps lower index
        clear_frame();
        bin_re[3] = 60; bin_im[7] = -60;
        bin_re[40] = 1000; bin_im[40] = 1000;
        model();
        send_bins("tie", NB, 0);
        wait_peak("tie");

        // most negative components
        clear_frame();
        bin_re[10] = -32768; bin_im[10] = -32768;
        model();
        send_bins("extreme", NB, 0);
        wait_peak("extreme");

        // all-zero frame
        clear_frame();
        model();
        send_bins("zero", NB, 0);
        wait_peak("zero");

        // gapped single tone
        clear_frame();
        bin_re[5] = 100; bin_im[5] = -50;
        model();
        send_bins("gap", NB, 1);
        wait_peak("gap");

        // abort mid-frame, then a full frame with peak at bin 9
        pv_before = pv_count;
        clear_frame();
        bin_re[5] = 5000;
        send_bins("abort_a", 20, 0);
        clear_frame();
        bin_re[9] = -700; bin_im[9] = 3;
        model();
        send_bins("abort_b", NB, 0);
        wait_peak("abort");
        check("abort_one_pulse", 32'(pv_count - pv_before), 32'd1);

        // in_valid while idle has no effect
        pv_before = pv_count;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_pulse", 32'(pv_count - pv_before), 32'd0);
        check("idle_bin_held", 32'(peak_bin), 32'd9);

        // random frames with random gaps
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NB; k++) begin
                bin_re[k] = int'($signed(DW'($urandom_range(0, 65535))));
                bin_im[k] = int'($signed(DW'($urandom_range(0, 65535))));
            end
            model();
            send_bins("rand", NB, 2);
            wait_peak("rand");
        end

        // reset mid-ACCUM, then keep feeding the rest of the frame
        clear_frame();
        bin_re[5] = 100; bin_im[5] = -50;
        pv_before = pv_count;
        send_bins("rstmid", 30, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_bin", 32'(peak_bin), 32'd0);
        check("rstmid_mag", 32'(peak_mag), 32'd0);
        for (int k = 30; k < NB; k++) begin
            in_valid = 1'b1;
            in_data  = pack_bin(k);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("rstmid_no_pulse", 32'(pv_count - pv_before), 32'd0);
        check("rstmid_busy_end", 32'(busy), 32'd0);

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("rst_start_busy_later", 32'(busy), 32'd0);

        // recovery frame
        clear_frame();
        bin_re[31] = 7; bin_im[31] = -8;
        model();
        send_bins("recover", NB, 0);
        wait_peak("recover");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
